// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter that hands one of two requesters the TX interface.
// Define TXARB_TIMEOUT_EN to add a watchdog that aborts a stalled TX handshake.
module tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [1:0]     req,
  input  logic [12143:0] req0_pktbuf,
  input  logic [12143:0] req1_pktbuf,
  input  logic [10:0]    req0_maxaddr,
  input  logic [10:0]    req1_maxaddr,
  output logic [1:0]     grant,
  output logic [1:0]     done,
  output logic           err,
  output logic [12143:0] tx_pktbuf,
  output logic [10:0]    tx_pktbuf_maxaddr,
  output logic           tx_doorbell,
  input  logic           tx_available
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RING       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_sel;
  logic       w_nextSel;
  logic       r_lastServed;
  logic       w_nextLastServed;
  logic [1:0] r_grant;
  logic [1:0] w_nextGrant;
  logic [1:0] r_done;
  logic [1:0] w_nextDone;
  logic       r_doorbell;
  logic       w_nextDoorbell;
  logic       w_winner;
  logic       w_timeout;

  // With both requesting, whoever was not served last time wins.
  assign w_winner = (req == 2'b10) ? 1'b1 :
                    (req == 2'b01) ? 1'b0 : ~r_lastServed;

  always_comb begin
    w_nextState      = r_state;
    w_nextSel        = r_sel;
    w_nextLastServed = r_lastServed;
    w_nextGrant      = r_grant;
    w_nextDone       = 2'b00;
    w_nextDoorbell   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_nextSel   = w_winner;
          w_nextGrant = w_winner ? 2'b10 : 2'b01;
          w_nextState = RING;
        end
      end
      RING: begin
        if (tx_available) begin
          w_nextDoorbell = 1'b1;
          w_nextState    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!tx_available) w_nextState = WAIT_END;
      end
      WAIT_END: begin
        if (tx_available) w_nextState = DONE;
      end
      default: w_nextState = IDLE;
    endcase
    if (w_timeout) w_nextState = DONE;
    // Completion bookkeeping happens on the edge that enters DONE.
    if ((w_nextState == DONE) && (r_state != DONE)) begin
      w_nextDone       = r_sel ? 2'b10 : 2'b01;
      w_nextGrant      = 2'b00;
      w_nextLastServed = r_sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_lastServed <= 1'b1;
      r_grant      <= 2'b00;
      r_done       <= 2'b00;
      r_doorbell   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_sel        <= w_nextSel;
      r_lastServed <= w_nextLastServed;
      r_grant      <= w_nextGrant;
      r_done       <= w_nextDone;
      r_doorbell   <= w_nextDoorbell;
    end
  end

`ifdef TXARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic [15:0] w_nextWdog;
  logic        r_err;
  logic        w_inWait;

  assign w_inWait  = (r_state == WAIT_START) || (r_state == WAIT_END);
  assign w_timeout = w_inWait && (r_wdog == (TIMEOUT_CYCLES - 16'd1));
  // The count restarts whenever a wait state is entered, including WAIT_START -> WAIT_END.
  assign w_nextWdog = (w_inWait && (w_nextState == r_state)) ? (r_wdog + 16'd1) : 16'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog <= 16'd0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= w_nextWdog;
      r_err  <= w_timeout;
    end
  end

  assign err = r_err;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = ^TIMEOUT_CYCLES;
  assign w_timeout       = 1'b0;
  assign err             = 1'b0;
`endif

  assign grant             = r_grant;
  assign done              = r_done;
  assign tx_doorbell       = r_doorbell;
  assign tx_pktbuf         = (r_grant != 2'b00) ? (r_sel ? req1_pktbuf : req0_pktbuf) : '0;
  assign tx_pktbuf_maxaddr = (r_grant != 2'b00) ? (r_sel ? req1_maxaddr : req0_maxaddr) : 11'd0;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter with a small TX interface model.
// Covers both builds; the watchdog scenario checks whichever TXARB_TIMEOUT_EN selects.
`timescale 1ns/1ps
module tb_tx_arbiter;

  localparam int BUFW = 12144;

  typedef enum int {TX_AUTO, TX_BUSY, TX_STUCK} txMode_t;
  typedef struct {
    logic [1:0] doneVal;
    logic       errVal;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [BUFW-1:0] buf0 = '0;
  logic [BUFW-1:0] buf1 = '0;
  logic [10:0]     maxaddr0 = 11'd0;
  logic [10:0]     maxaddr1 = 11'd0;
  logic [1:0]      grant;
  logic [1:0]      done;
  logic            err;
  logic [BUFW-1:0] tx_pktbuf;
  logic [10:0]     tx_pktbuf_maxaddr;
  logic            tx_doorbell;
  logic            tx_available;

  exp_t    expQ[$];
  exp_t    popped;
  int      nCompared = 0;
  int      nMismatched = 0;
  int      dbCount = 0;
  int      txBusy = 5;
  txMode_t txMode = TX_AUTO;
  logic    mLast = 1'b1;

  tx_arbiter #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .req               (req),
    .req0_pktbuf       (buf0),
    .req1_pktbuf       (buf1),
    .req0_maxaddr      (maxaddr0),
    .req1_maxaddr      (maxaddr1),
    .grant             (grant),
    .done              (done),
    .err               (err),
    .tx_pktbuf         (tx_pktbuf),
    .tx_pktbuf_maxaddr (tx_pktbuf_maxaddr),
    .tx_doorbell       (tx_doorbell),
    .tx_available      (tx_available)
  );

  always #10 clk = ~clk;

  // Round-robin reference: a lone requester wins, otherwise the one not served last.
  function automatic logic predict(input logic [1:0] r);
    logic w;
    if (r == 2'b01) w = 1'b0;
    else if (r == 2'b10) w = 1'b1;
    else w = ~mLast;
    mLast = w;
    return w;
  endfunction

  // TX interface model: auto mode drops available 2 cycles after a doorbell for txBusy cycles.
  initial begin
    tx_available = 1'b1;
    forever begin
      @(negedge clk);
      if (txMode == TX_BUSY) begin
        tx_available = 1'b0;
      end else if (txMode == TX_AUTO && tx_doorbell === 1'b1) begin
        repeat (2) @(negedge clk);
        tx_available = 1'b0;
        repeat (txBusy) @(negedge clk);
        tx_available = 1'b1;
      end else begin
        tx_available = 1'b1;
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (tx_doorbell === 1'b1) dbCount++;
    if (rstn === 1'b1 && done !== 2'b00) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_done: got done=%b err=%b, required no done", done, err);
      end else begin
        popped = expQ.pop_front();
        if (done !== popped.doneVal || err !== popped.errVal || grant !== 2'b00) begin
          nMismatched++;
          $display("[TB] FAIL done_pulse: got done=%b err=%b grant=%b, required done=%b err=%b grant=00",
                   done, err, grant, popped.doneVal, popped.errVal);
        end
      end
    end else if (rstn === 1'b1) begin
      nCompared++;
      if (err !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL err_without_done: got err=%b, required 0", err);
      end
    end
  end

  task test_reset;
    rstn = 1'b0;
    req  = 2'b00;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({grant, done, err, tx_doorbell} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got grant=%b done=%b err=%b doorbell=%b, required all 0",
               grant, done, err, tx_doorbell);
    end
    nCompared++;
    if (tx_pktbuf_maxaddr !== 11'd0 || tx_pktbuf !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_txbuf: got maxaddr=%0d buf[63:0]=%h, required 0", tx_pktbuf_maxaddr, tx_pktbuf[63:0]);
    end
    rstn  = 1'b1;
    mLast = 1'b1;
    repeat (2) @(negedge clk);
    nCompared++;
    if (grant !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL idle_grant: got %b, required 00", grant);
    end
  endtask

  task test_single;
    int   base;
    int   cyc;
    logic stable;
    txMode   = TX_AUTO;
    txBusy   = 5;
    maxaddr0 = 11'd59;
    base     = dbCount;
    void'(predict(2'b01));
    expQ.push_back('{2'b01, 1'b0});
    req = 2'b01;
    @(negedge clk);
    nCompared++;
    if (grant !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL single_grant: got %b, required 01", grant);
    end
    nCompared++;
    if (tx_pktbuf_maxaddr !== 11'd59) begin
      nMismatched++;
      $display("[TB] FAIL single_maxaddr: got %0d, required 59", tx_pktbuf_maxaddr);
    end
    nCompared++;
    if (tx_pktbuf !== buf0) begin
      nMismatched++;
      $display("[TB] FAIL single_txbuf: got [63:0]=%h, required %h", tx_pktbuf[63:0], buf0[63:0]);
    end
    @(negedge clk);
    nCompared++;
    if (tx_doorbell !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL single_doorbell_latency: got %b, required 1", tx_doorbell);
    end
    stable = 1'b1;
    cyc    = 0;
    while (done === 2'b00 && cyc < 500) begin
      if (grant !== 2'b01) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    req = 2'b00;
    nCompared++;
    if (cyc >= 500) begin
      nMismatched++;
      $display("[TB] FAIL single_done_wait: got no done in %0d cycles, required done", cyc);
    end
    nCompared++;
    if (!stable) begin
      nMismatched++;
      $display("[TB] FAIL single_grant_stable: got grant change mid-frame, required constant 01");
    end
    repeat (10) @(negedge clk);
    nCompared++;
    if (dbCount - base != 1) begin
      nMismatched++;
      $display("[TB] FAIL single_doorbells: got %0d, required 1", dbCount - base);
    end
  endtask

  task test_avail_low;
    int   base;
    int   cyc;
    logic stable;
    txMode   = TX_BUSY;
    txBusy   = 4;
    maxaddr1 = 11'd700;
    repeat (2) @(negedge clk);
    base = dbCount;
    void'(predict(2'b10));
    expQ.push_back('{2'b10, 1'b0});
    req    = 2'b10;
    stable = 1'b1;
    @(negedge clk);
    nCompared++;
    if (tx_pktbuf_maxaddr !== 11'd700 || tx_pktbuf !== buf1) begin
      nMismatched++;
      $display("[TB] FAIL busy_txbuf: got maxaddr=%0d buf[63:0]=%h, required 700 %h",
               tx_pktbuf_maxaddr, tx_pktbuf[63:0], buf1[63:0]);
    end
    repeat (100) begin
      if (grant !== 2'b10) stable = 1'b0;
      @(negedge clk);
    end
    nCompared++;
    if (!stable || grant !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL busy_grant_hold: got %b, required 10 throughout", grant);
    end
    nCompared++;
    if (dbCount - base != 0) begin
      nMismatched++;
      $display("[TB] FAIL busy_no_doorbell: got %0d, required 0", dbCount - base);
    end
    txMode = TX_AUTO;
    cyc    = 0;
    while (done === 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    req = 2'b00;
    nCompared++;
    if (cyc >= 200) begin
      nMismatched++;
      $display("[TB] FAIL busy_done_wait: got no done in %0d cycles, required done", cyc);
    end
    repeat (5) @(negedge clk);
    nCompared++;
    if (dbCount - base != 1) begin
      nMismatched++;
      $display("[TB] FAIL busy_doorbells: got %0d, required 1", dbCount - base);
    end
  endtask

  task test_round_robin;
    int         base;
    int         cyc;
    logic       w;
    logic [1:0] expG;
    txMode = TX_AUTO;
    txBusy = 3;
    base   = dbCount;
    req    = 2'b11;
    for (int f = 0; f < 3; f++) begin
      w    = predict(2'b11);
      expG = w ? 2'b10 : 2'b01;
      expQ.push_back('{expG, 1'b0});
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (grant === 2'b00 && cyc < 10);
      nCompared++;
      if (grant !== expG) begin
        nMismatched++;
        $display("[TB] FAIL rr_grant frame %0d: got %b, required %b", f, grant, expG);
      end
      nCompared++;
      if (tx_pktbuf_maxaddr !== (w ? maxaddr1 : maxaddr0)) begin
        nMismatched++;
        $display("[TB] FAIL rr_maxaddr frame %0d: got %0d, required %0d", f, tx_pktbuf_maxaddr,
                 w ? maxaddr1 : maxaddr0);
      end
      cyc = 0;
      while (done === 2'b00 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      nCompared++;
      if (cyc >= 200) begin
        nMismatched++;
        $display("[TB] FAIL rr_done_wait frame %0d: got no done, required done", f);
      end
      if (f == 2) req = 2'b00;
    end
    repeat (5) @(negedge clk);
    nCompared++;
    if (dbCount - base != 3) begin
      nMismatched++;
      $display("[TB] FAIL rr_doorbells: got %0d, required 3", dbCount - base);
    end
  endtask

  task test_reset_mid_frame;
    int cyc;
    txMode = TX_AUTO;
    txBusy = 30;
    req    = 2'b10;
    cyc    = 0;
    while (tx_doorbell !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    nCompared++;
    if (cyc >= 10) begin
      nMismatched++;
      $display("[TB] FAIL midreset_doorbell_wait: got no doorbell, required one");
    end
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    nCompared++;
    if ({grant, done, err, tx_doorbell} !== 6'b0 || tx_pktbuf_maxaddr !== 11'd0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got grant=%b done=%b err=%b doorbell=%b maxaddr=%0d, required all 0",
               grant, done, err, tx_doorbell, tx_pktbuf_maxaddr);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
    rstn  = 1'b1;
    mLast = 1'b1;
    cyc   = 0;
    while (tx_available !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    void'(predict(2'b11));
    expQ.push_back('{2'b01, 1'b0});
    req = 2'b11;
    @(negedge clk);
    nCompared++;
    if (grant !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL midreset_first_grant: got %b, required 01", grant);
    end
    cyc = 0;
    while (done === 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    req = 2'b00;
    nCompared++;
    if (cyc >= 200) begin
      nMismatched++;
      $display("[TB] FAIL midreset_done_wait: got no done, required done");
    end
    repeat (3) @(negedge clk);
  endtask

  task test_timeout;
    int   base;
    int   cyc;
    logic doneSeen;
    logic errSeen;
    txMode = TX_STUCK;
    repeat (2) @(negedge clk);
    base = dbCount;
    void'(predict(2'b01));
`ifdef TXARB_TIMEOUT_EN
    expQ.push_back('{2'b01, 1'b1});
`endif
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if (tx_doorbell !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL wd_doorbell: got %b, required 1", tx_doorbell);
    end
    cyc      = 0;
    doneSeen = 1'b0;
    errSeen  = 1'b0;
`ifdef TXARB_TIMEOUT_EN
    while (done === 2'b00 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    req = 2'b00;
    nCompared++;
    if (cyc != 20) begin
      nMismatched++;
      $display("[TB] FAIL wd_latency: got done after %0d cycles, required 20", cyc);
    end
`else
    repeat (60) begin
      @(negedge clk);
      if (done !== 2'b00) doneSeen = 1'b1;
      if (err !== 1'b0) errSeen = 1'b1;
    end
    nCompared++;
    if (doneSeen || errSeen) begin
      nMismatched++;
      $display("[TB] FAIL nowd_stall: got done=%b err=%b seen, required neither", doneSeen, errSeen);
    end
    nCompared++;
    if (grant !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL nowd_grant_hold: got %b, required 01", grant);
    end
    expQ.push_back('{2'b01, 1'b0});
    txMode = TX_BUSY;
    repeat (3) @(negedge clk);
    txMode = TX_STUCK;
    while (done === 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    req = 2'b00;
    nCompared++;
    if (cyc >= 20) begin
      nMismatched++;
      $display("[TB] FAIL nowd_release: got no done, required done");
    end
`endif
    repeat (5) @(negedge clk);
    nCompared++;
    if (dbCount - base != 1 || grant !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL wd_end_state: got doorbells=%0d grant=%b, required 1 00", dbCount - base, grant);
    end
  endtask

  initial begin
    for (int i = 0; i < 1518; i++) begin
      buf0[i*8 +: 8] = 8'($urandom);
      buf1[i*8 +: 8] = 8'($urandom);
    end
    maxaddr1 = 11'd1517;
    test_reset;
    test_single;
    test_avail_low;
    test_round_robin;
    test_reset_mid_frame;
    test_timeout;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL pending_done: got %0d outstanding, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
